// File: rtl/demux32_buf.sv
// Buffered 1-to-2 demultiplexer: each beat is steered by in_sel into one of two independent FIFOs.
// Latency 1 cycle from acceptance to outX_valid; in_ready drops only when the selected FIFO is full.

// Per-output FIFO: register-array storage, combinational head read.
// Latency: pushed beat visible on o_pop_dat the cycle after the push edge (no bypass).
// Backpressure: o_full tells the steering logic to hold the producer; pops never wait on pushes.
module demux32_buf_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop_rdy,
    output logic             o_pop_vld,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic [CW-1:0]    o_count,
    output logic             o_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop     = (r_count != '0) && i_pop_rdy;
    assign o_pop_vld = (r_count != '0);
    assign o_pop_dat = r_mem[r_rptr];
    assign o_count   = r_count;
    assign o_full    = (r_count == CNT_MAX);

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push_vld) begin
                r_mem[r_wptr] <= i_push_dat;
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({i_push_vld, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// Steers the input stream into FIFO0/FIFO1 by in_sel.
// Latency: 1 cycle, accepted beat appears on outX the cycle after the accepting edge.
// Backpressure: in_ready is a function of in_sel and the target FIFO's count only, never of outX_ready.
module demux32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CW-1:0]    count0,
    output logic [CW-1:0]    count1
);

    logic w_full0;
    logic w_full1;
    logic w_push0;
    logic w_push1;

    // A full FIFO refuses even when its consumer pops this cycle: no pass-through path.
    assign in_ready = in_sel ? !w_full1 : !w_full0;
    assign w_push0  = in_valid && in_ready && !in_sel;
    assign w_push1  = in_valid && in_ready &&  in_sel;

    demux32_buf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_vld (w_push0),
        .i_push_dat (in_data),
        .i_pop_rdy  (out0_ready),
        .o_pop_vld  (out0_valid),
        .o_pop_dat  (out0_data),
        .o_count    (count0),
        .o_full     (w_full0)
    );

    demux32_buf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_vld (w_push1),
        .i_push_dat (in_data),
        .i_pop_rdy  (out1_ready),
        .o_pop_vld  (out1_valid),
        .o_pop_dat  (out1_data),
        .o_count    (count1),
        .o_full     (w_full1)
    );

endmodule

// File: tb/tb_demux32_buf.sv
// Bench for demux32_buf: per-output queue model, directed scenarios plus a random soak.
module tb_demux32_buf;

    localparam int WIDTH = 32;
    localparam int DEP   = 2;
    localparam int CW    = $clog2(DEP) + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CW-1:0]    count0;
    logic [CW-1:0]    count1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    bit               last_acc = 0;

    demux32_buf #(.WIDTH(WIDTH), .DEPTH(DEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .count0     (count0),
        .count1     (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: accept when the selected queue holds fewer than DEP beats; pop heads on ready.
    task automatic tick();
        bit acc, p0, p1;
        logic [WIDTH-1:0] d;
        bit s;
        acc = in_valid && ((in_sel ? q1.size() : q0.size()) < DEP);
        p0  = out0_ready && (q0.size() > 0);
        p1  = out1_ready && (q1.size() > 0);
        d   = in_data;
        s   = in_sel;
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (DEP + 1) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = $urandom;
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n_checks++;
            if ({out0_valid, out1_valid, count0, count1, in_ready} !== {1'b0, 1'b0, CW'(0), CW'(0), 1'b1}) begin
                n_fail++;
                $display("FAIL reset_ctrl: got v0=%b v1=%b c0=%0d c1=%0d rdy=%b, expected 0 0 0 0 1",
                         out0_valid, out1_valid, count0, count1, in_ready);
            end
            n_checks++;
            if (out0_data !== '0 || out1_data !== '0) begin
                n_fail++;
                $display("FAIL reset_data: got d0=%h d1=%h expected 0 0", out0_data, out1_data);
            end
        end
        @(negedge clk);
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        rst_n      = 1'b1;
        q0.delete();
        q1.delete();
        // Buffer one beat per output, then drop reset between edges.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1111_2222;
        tick();
        in_sel = 1'b1; in_data = 32'h3333_4444;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (count0 !== CW'(1) || count1 !== CW'(1)) begin
            n_fail++;
            $display("FAIL reset_prefill: got c0=%0d c1=%0d expected 1 1", count0, count1);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out0_valid, out1_valid, count0, count1, in_ready} !== {1'b0, 1'b0, CW'(0), CW'(0), 1'b1}
            || out0_data !== '0 || out1_data !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got v0=%b v1=%b c0=%0d c1=%0d rdy=%b d0=%h d1=%h, expected all 0 and rdy 1",
                     out0_valid, out1_valid, count0, count1, in_ready, out0_data, out1_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_steering();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA_0001;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL steer_first: got rdy=%b v0=%b expected 1 0", in_ready, out0_valid);
        end
        tick();
        in_sel = 1'b1; in_data = 32'h5555_0002;
        #1;
        n_checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'hAAAA_0001 || out1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL steer_out0: got v0=%b d0=%h v1=%b expected 1 aaaa0001 0", out0_valid, out0_data, out1_valid);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h5555_0002 || out0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL steer_out1: got v1=%b d1=%h v0=%b expected 1 55550002 0", out1_valid, out1_data, out0_valid);
        end
        tick();
        #1;
        n_checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL steer_empty: got v0=%b v1=%b expected 0 0", out0_valid, out1_valid);
        end
    endtask

    task automatic test_backpressure();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        in_data = 32'hB000_0001; tick();
        in_data = 32'hB000_0002; tick();
        in_data = 32'hB000_0003;
        #1;
        n_checks++;
        if (count0 !== CW'(2) || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got c0=%0d rdy=%b expected 2 0", count0, in_ready);
        end
        tick();
        in_sel = 1'b1; in_data = 32'hC000_0001;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_other_side: got rdy=%b expected 1", in_ready);
        end
        tick();
        n_checks++;
        if (count1 !== CW'(1) || out1_data !== 32'hC000_0001) begin
            n_fail++;
            $display("FAIL bp_other_data: got c1=%0d d1=%h expected 1 c0000001", count1, out1_data);
        end
        out0_ready = 1'b1;
        in_sel = 1'b0; in_data = 32'hB000_0003;
        #1;
        n_checks++;
        if (out0_data !== 32'hB000_0001 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain1: got d0=%h rdy=%b expected b0000001 0", out0_data, in_ready);
        end
        tick();
        #1;
        n_checks++;
        if (out0_data !== 32'hB000_0002 || in_ready !== 1'b1 || count0 !== CW'(1)) begin
            n_fail++;
            $display("FAIL bp_drain2: got d0=%h rdy=%b c0=%0d expected b0000002 1 1", out0_data, in_ready, count0);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out0_data !== 32'hB000_0003 || count0 !== CW'(1)) begin
            n_fail++;
            $display("FAIL bp_drain3: got d0=%h c0=%0d expected b0000003 1", out0_data, count0);
        end
        drain();
    endtask

    task automatic test_push_pop_full();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        for (int k = 0; k < DEP; k++) begin
            in_data = 32'hD000_0000 + k;
            tick();
        end
        out0_ready = 1'b1;
        in_data = 32'hD000_00FF;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || count0 !== CW'(DEP)) begin
            n_fail++;
            $display("FAIL ppf_refuse: got rdy=%b c0=%0d expected 0 %0d", in_ready, count0, DEP);
        end
        tick();
        out0_ready = 1'b0;
        #1;
        n_checks++;
        if (count0 !== CW'(DEP - 1) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ppf_after_pop: got c0=%0d rdy=%b expected %0d 1", count0, in_ready, DEP - 1);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (count0 !== CW'(DEP) || q0.size() != DEP || !last_acc) begin
            n_fail++;
            $display("FAIL ppf_accept: got c0=%0d expected %0d", count0, DEP);
        end
        drain();
    endtask

    task automatic test_wrap_order();
        logic [WIDTH-1:0] rx[$];
        int i = 0;
        int cyc = 0;
        out0_ready = 1'b0;
        while (rx.size() < 10 && cyc < 300) begin
            in_valid   = (i < 10);
            in_sel     = 1'b1;
            in_data    = WIDTH'(i);
            out1_ready = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (count1 > CW'(DEP) || count1 !== CW'(q1.size())) begin
                n_fail++;
                $display("FAIL wrap_count: got c1=%0d expected %0d", count1, q1.size());
            end
            if (out1_valid && out1_ready) rx.push_back(out1_data);
            tick();
            if (last_acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (rx.size() != 10) begin
            n_fail++;
            $display("FAIL wrap_timeout: got %0d beats expected 10", rx.size());
        end
        for (int k = 0; k < rx.size(); k++) begin
            n_checks++;
            if (rx[k] !== WIDTH'(k)) begin
                n_fail++;
                $display("FAIL wrap_order[%0d]: got %h expected %h", k, rx[k], WIDTH'(k));
            end
        end
        drain();
    endtask

    task automatic test_soak();
        int sent = 0;
        int cyc  = 0;
        bit pend = 0;
        while ((sent < 1000 || q0.size() > 0 || q1.size() > 0) && cyc < 20000) begin
            if (!pend) begin
                in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = $urandom;
                pend     = in_valid;
            end
            out0_ready = 1'($urandom_range(0, 2) != 0);
            out1_ready = 1'($urandom_range(0, 2) != 0);
            #1;
            n_checks++;
            if (in_ready !== ((in_sel ? q1.size() : q0.size()) < DEP)) begin
                n_fail++;
                $display("FAIL soak_in_ready: cyc %0d got %b q0=%0d q1=%0d sel=%b", cyc, in_ready, q0.size(), q1.size(), in_sel);
            end
            n_checks++;
            if (count0 !== CW'(q0.size()) || count1 !== CW'(q1.size())
                || out0_valid !== (q0.size() > 0) || out1_valid !== (q1.size() > 0)) begin
                n_fail++;
                $display("FAIL soak_occupancy: cyc %0d got c0=%0d c1=%0d v0=%b v1=%b expected %0d %0d",
                         cyc, count0, count1, out0_valid, out1_valid, q0.size(), q1.size());
            end
            if (q0.size() > 0) begin
                n_checks++;
                if (out0_data !== q0[0]) begin
                    n_fail++;
                    $display("FAIL soak_out0_data: cyc %0d got %h expected %h", cyc, out0_data, q0[0]);
                end
            end
            if (q1.size() > 0) begin
                n_checks++;
                if (out1_data !== q1[0]) begin
                    n_fail++;
                    $display("FAIL soak_out1_data: cyc %0d got %h expected %h", cyc, out1_data, q1[0]);
                end
            end
            tick();
            if (last_acc) begin
                sent++;
                pend = 0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (sent != 1000 || q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL soak_timeout: got sent=%0d q0=%0d q1=%0d expected 1000 0 0", sent, q0.size(), q1.size());
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_steering();
        test_backpressure();
        test_push_pop_full();
        test_wrap_order();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/demux32_buf.md
# demux32_buf

Buffered 1-to-2 demultiplexer that steers a WIDTH-bit data stream to one of two consumers under a per-beat select bit. It performs the inverse of the two-input word selector. The datapath uses it wherever one producer (e.g. the shared memory response path) feeds two destinations (e.g. the fetch stage and the load/store stage). Each destination gets its own DEPTH-entry FIFO with valid/ready handshakes, so back-pressure on one output never reorders or corrupts traffic to the other.

## Interface

Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 2, entries per output FIFO; power of two, >= 2
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a beat on in_data/in_sel
- in_ready  output  1  beat accepted this cycle if in_valid is also high
- in_sel  input  1  destination of the beat: 0 = out0, 1 = out1
- in_data  input  WIDTH  beat payload
- out0_valid  output  1  FIFO0 non-empty; out0_data is valid
- out0_ready  input  1  consumer 0 takes the head beat
- out0_data  output  WIDTH  head of FIFO0
- out1_valid, out1_ready, out1_data: same as out0, for FIFO1
- count0  output  CW  FIFO0 occupancy, 0..DEPTH
- count1  output  CW  FIFO1 occupancy, 0..DEPTH

## Operation

- in_ready = (in_sel ? count1 : count0) != DEPTH. It is combinational from in_sel and the registered counts. It never depends on outX_ready, so there is no pass-through when a FIFO is full.
- Push: when in_valid && in_ready, in_data is written at FIFO[in_sel] write pointer. That write pointer increments modulo DEPTH.
- Pop: when outX_valid && outX_ready, FIFO X read pointer increments modulo DEPTH.
- countX next value:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop to the same FIFO, or on neither
- outX_valid = (countX != 0).
- outX_data = storage[read pointer], read combinationally from registers. It holds stable while outX_valid && !outX_ready.
- Beats to the same output leave in arrival order. The two FIFOs are fully independent: a stall on out0 never blocks a beat with in_sel=1.
- Beats not accepted are not stored. The producer must hold in_data and in_sel stable until accepted; behaviour otherwise is not defined.
- Reset (asynchronous, rst_n low):
  - pointers, counts and all storage go to 0
  - out0_valid = out1_valid = 0, out0_data = out1_data = 0, count0 = count1 = 0
  - in_ready = 1
  - Reset mid-transfer discards all buffered beats. The first edge with rst_n high performs normal operation.

## Timing

- Latency: a beat accepted at edge N appears on outX_data with outX_valid = 1 immediately after edge N. Minimum residency is one cycle; there is no same-cycle bypass.
- Throughput: one beat per cycle per input when the target FIFO is not full. Each output sustains one pop per cycle.
- Full FIFO with a pop and an offered push in the same cycle: in_ready = 0, the pop completes, and the push is accepted next cycle.
- Empty FIFO with a push: outX_valid rises the following cycle. An outX_ready asserted the same cycle has no effect.
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0. Ordering is preserved across the wrap.
- in_ready may toggle within a cycle if in_sel changes. Producers sample it only together with in_sel.

## Test plan

- Reset: hold rst_n = 0 with random inputs. Required: out0_valid = out1_valid = 0, counts = 0, outX_data = 0, in_ready = 1. Assert rst_n = 0 asynchronously mid-cycle with two beats buffered; all of those go to 0 without waiting for a clock edge.
- Steering: push 0xAAAA0001 (sel=0) then 0x55550002 (sel=1), both outputs ready. Required: out0 emits 0xAAAA0001 one cycle after acceptance and out1 emits 0x55550002 one cycle after its own acceptance. No cross-delivery.
- Full/back-pressure: out0_ready = 0, push three sel=0 beats (DEPTH=2). Required:
  - count0 = 2 and in_ready = 0 on the third beat
  - a sel=1 beat offered next is accepted immediately
  - after raising out0_ready, beats drain in order 1, 2, then the third is accepted
- Simultaneous push/pop at full: count0 = 2, out0_ready = 1, sel=0 beat offered. Required: in_ready = 0 that cycle, count0 = 1 next, beat accepted next cycle, count0 stays 2 after.
- Wrap and order: continuous stream of 0..9 to out1 with out1_ready toggling pseudo-randomly. Required: out1 emits exactly 0..9 in order, count1 never exceeds 2, no duplicated or lost beats.
- Interleave soak: 1000 random beats with random sel and random readiness on both outputs. A scoreboard per output checks order and content; counts match the scoreboard depth every cycle.
